// File: rtl/wb_merge.sv
`default_nettype none
// ============================================================================
//  Module   : wb_merge
//  Purpose  : Completion buffer and writeback merger. Each of NR_SRC result
//             sources feeds its own DEPTH-entry FIFO; a round-robin arbiter
//             drains one head entry per cycle into a registered writeback
//             port shared by the register file and the ROB.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   clock, rising edge
//    rstn         in   asynchronous active-low reset
//    flush_i      in   drop every buffered result and the same-cycle traffic
//    src_valid_i  in   [NR_SRC]          per-source result valid
//    src_ready_o  out  [NR_SRC]          per-source FIFO has a free entry
//    src_id_i     in   [NR_SRC*ID_W]     packed ROB ids (source k at k*ID_W)
//    src_rd_i     in   [NR_SRC*RD_W]     packed destination registers
//    src_we_i     in   [NR_SRC]          result writes a register
//    src_data_i   in   [NR_SRC*DATA_W]   packed results
//    wb_valid_o   out  one cycle per completing result
//    wb_id_o      out  ROB id of completing result
//    wb_rd_o      out  destination register
//    wb_we_o      out  register-file write enable, low whenever wb_valid_o is low
//    wb_data_o    out  result value
//    busy_o       out  any FIFO non-empty or wb_valid_o high
// ============================================================================
module wb_merge #(
    parameter int NR_SRC = 3,
    parameter int DEPTH  = 2,
    parameter int ID_W   = 6,
    parameter int RD_W   = 5,
    parameter int DATA_W = 64
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       flush_i,
    input  logic [NR_SRC-1:0]          src_valid_i,
    output logic [NR_SRC-1:0]          src_ready_o,
    input  logic [NR_SRC*ID_W-1:0]     src_id_i,
    input  logic [NR_SRC*RD_W-1:0]     src_rd_i,
    input  logic [NR_SRC-1:0]          src_we_i,
    input  logic [NR_SRC*DATA_W-1:0]   src_data_i,
    output logic                       wb_valid_o,
    output logic [ID_W-1:0]            wb_id_o,
    output logic [RD_W-1:0]            wb_rd_o,
    output logic                       wb_we_o,
    output logic [DATA_W-1:0]          wb_data_o,
    output logic                       busy_o
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH) + 1;
    localparam int c_SEL_W = $clog2(NR_SRC);
    // FIFO entry layout, MSB first: {id, rd, we, data}
    localparam int c_ENT_W = ID_W + RD_W + 1 + DATA_W;

    logic [NR_SRC-1:0]              w_push;
    logic [NR_SRC-1:0]              w_pop;
    logic [NR_SRC-1:0]              w_nonempty;
    logic [NR_SRC-1:0][c_ENT_W-1:0] w_head;

    logic [c_SEL_W-1:0]             r_rr;
    logic [c_SEL_W-1:0]             w_win;
    logic [c_SEL_W-1:0]             w_rr_next;
    logic                           w_found;
    logic [c_ENT_W-1:0]             w_win_ent;

    logic                           r_wb_valid;
    logic [ID_W-1:0]                r_wb_id;
    logic [RD_W-1:0]                r_wb_rd;
    logic                           r_wb_we;
    logic [DATA_W-1:0]              r_wb_data;

    function automatic logic [c_PTR_W-1:0] f_ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
    endfunction

    // (base + off) mod NR_SRC for off < NR_SRC, done as one conditional
    // subtract so no divider is built for non-power-of-two source counts.
    function automatic logic [c_SEL_W-1:0] f_rr_add(input logic [c_SEL_W-1:0] base,
                                                    input int               off);
        int s;
        s = int'(base) + off;
        if (s >= NR_SRC) begin
            s = s - NR_SRC;
        end
        return c_SEL_W'(s);
    endfunction

    // ------------------------------------------------------------------------
    // Per-source FIFOs
    // ------------------------------------------------------------------------
    generate
        for (genvar k = 0; k < NR_SRC; k++) begin : g_src
            logic [c_ENT_W-1:0] r_mem [DEPTH];
            logic [c_PTR_W-1:0] r_wr_ptr;
            logic [c_PTR_W-1:0] r_rd_ptr;
            logic [c_CNT_W-1:0] r_cnt;

            // Ready looks only at the registered count, so a pop in the same
            // cycle never opens a slot combinationally.
            assign src_ready_o[k] = (r_cnt < c_CNT_W'(DEPTH));
            assign w_push[k]      = src_valid_i[k] & src_ready_o[k] & ~flush_i;
            assign w_pop[k]       = w_found & (w_win == c_SEL_W'(k)) & ~flush_i;
            assign w_nonempty[k]  = (r_cnt != '0);
            assign w_head[k]      = r_mem[r_rd_ptr];

            always_ff @(posedge clk) begin
                if (w_push[k]) begin
                    r_mem[r_wr_ptr] <= {src_id_i[k*ID_W +: ID_W],
                                        src_rd_i[k*RD_W +: RD_W],
                                        src_we_i[k],
                                        src_data_i[k*DATA_W +: DATA_W]};
                end
            end

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_cnt    <= '0;
                end else if (flush_i) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_cnt    <= '0;
                end else begin
                    if (w_push[k]) begin
                        r_wr_ptr <= f_ptr_inc(r_wr_ptr);
                    end
                    if (w_pop[k]) begin
                        r_rd_ptr <= f_ptr_inc(r_rd_ptr);
                    end
                    if (w_push[k] && !w_pop[k]) begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end else if (!w_push[k] && w_pop[k]) begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Round-robin arbiter: first non-empty source at or after r_rr
    // ------------------------------------------------------------------------
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 0; i < NR_SRC; i++) begin
            if (!w_found && w_nonempty[f_rr_add(r_rr, i)]) begin
                w_found = 1'b1;
                w_win   = f_rr_add(r_rr, i);
            end
        end
    end

    assign w_rr_next = (w_win == c_SEL_W'(NR_SRC - 1)) ? '0 : w_win + c_SEL_W'(1);
    assign w_win_ent = w_head[w_win];

    // ------------------------------------------------------------------------
    // Registered writeback port
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rr       <= '0;
            r_wb_valid <= 1'b0;
            r_wb_id    <= '0;
            r_wb_rd    <= '0;
            r_wb_we    <= 1'b0;
            r_wb_data  <= '0;
        end else if (flush_i) begin
            r_rr       <= '0;
            r_wb_valid <= 1'b0;
        end else if (w_found) begin
            r_rr       <= w_rr_next;
            r_wb_valid <= 1'b1;
            r_wb_id    <= w_win_ent[DATA_W+1+RD_W +: ID_W];
            r_wb_rd    <= w_win_ent[DATA_W+1 +: RD_W];
            r_wb_we    <= w_win_ent[DATA_W];
            r_wb_data  <= w_win_ent[DATA_W-1:0];
        end else begin
            // Payload fields keep their last value while idle.
            r_wb_valid <= 1'b0;
        end
    end

    assign wb_valid_o = r_wb_valid;
    assign wb_id_o    = r_wb_id;
    assign wb_rd_o    = r_wb_rd;
    assign wb_we_o    = r_wb_valid & r_wb_we;
    assign wb_data_o  = r_wb_data;
    assign busy_o     = (|w_nonempty) | r_wb_valid;

endmodule
`default_nettype wire
